// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: two-stage pipelined unsigned multiplier with a selectable
// approximate mode. In approximate mode the lowest APPROX_COLS partial-product
// columns are collapsed to a single OR bit each and never generate a carry;
// all higher columns are summed exactly.
module approx_mult_pipe #(
   parameter int WIDTH       = 4,
   parameter int APPROX_COLS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic                 out_mode,
   output logic [15:0]          op_count
);

   localparam int P_W = 2 * WIDTH;

   // Bits set in this mask mark the approximated (carry-free) columns.
   localparam logic [P_W-1:0] LOW_MASK = P_W'((64'd1 << APPROX_COLS) - 64'd1);

   // Stage 1: captured operands
   logic                s1_valid_reg;
   logic [WIDTH-1:0]    s1_a_reg;
   logic [WIDTH-1:0]    s1_b_reg;
   logic                s1_mode_reg;

   // Stage 2: registered product
   logic                s2_valid_reg;
   logic [P_W-1:0]      p_reg;
   logic                out_mode_reg;

   logic [15:0]         op_count_reg;

   logic                s2_load;
   logic                out_fire;
   logic                in_fire;

   logic [P_W-1:0]      row_terms [WIDTH];
   logic [P_W-1:0]      exact_sum;
   logic [P_W-1:0]      hi_sum;
   logic [P_W-1:0]      low_or;
   logic [P_W-1:0]      approx_sum;
   logic [P_W-1:0]      p_next;

   // Handshake: stage 2 may load when empty or draining this cycle, and
   // stage 1 frees up whenever stage 2 takes its contents.
   assign out_fire = s2_valid_reg && out_ready;
   assign s2_load  = !s2_valid_reg || out_ready;
   assign in_ready = !s1_valid_reg || s2_load;
   assign in_fire  = in_valid && in_ready;

   // One shifted row of partial products per multiplier bit; column k of the
   // partial-product array is bit k across all rows.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
      assign row_terms[gi] = s1_b_reg[gi] ? (P_W'(s1_a_reg) << gi) : '0;
   end

   // Exact and approximate reductions of the partial-product rows.
   // High columns are summed with their low bits stripped, so carries can only
   // originate at column APPROX_COLS or above; low columns are OR-reduced and
   // merged in without any addition.
   always_comb begin
      exact_sum = '0;
      hi_sum    = '0;
      low_or    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         exact_sum = exact_sum + row_terms[i];
         hi_sum    = hi_sum + (row_terms[i] & ~LOW_MASK);
         low_or    = low_or | row_terms[i];
      end
      approx_sum = hi_sum | (low_or & LOW_MASK);
      p_next     = s1_mode_reg ? approx_sum : exact_sum;
   end

   // Stage 1 register: accepts new operands whenever in_ready is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_a_reg     <= '0;
         s1_b_reg     <= '0;
         s1_mode_reg  <= 1'b0;
      end else if (in_ready) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_a_reg    <= a;
            s1_b_reg    <= b;
            s1_mode_reg <= mode;
         end
      end
   end

   // Stage 2 register: holds the product stable while downstream stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         p_reg        <= '0;
         out_mode_reg <= 1'b0;
      end else if (s2_load) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            p_reg        <= p_next;
            out_mode_reg <= s1_mode_reg;
         end
      end
   end

   // Completed output transfers, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_count_reg <= '0;
      end else if (out_fire) begin
         op_count_reg <= op_count_reg + 16'd1;
      end
   end

   assign out_valid = s2_valid_reg;
   assign p         = p_reg;
   assign out_mode  = out_mode_reg;
   assign op_count  = op_count_reg;

endmodule
